seven_seg_mux: RTL and testbench

Parametrised N-digit time-multiplexed seven-segment display driver. It drives one shared segment bus and a one-hot digit-select bus, stepping through DIGITS digits at a programmable refresh rate. Segment data is captured into a shadow frame register once per full scan, so a display never shows a torn frame. It sits between the display-formatting logic (which supplies packed segment patterns) and the board-level segment and anode pins.

---
 rtl/seven_seg_mux.sv | 108 ++++++++++
 tb/tb_seven_seg_mux.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed N-digit seven-segment driver with a per-frame shadow capture.
// Latency: all outputs are registered and change on the step edge; one step every DIV+1 enabled cycles.
// Flow control: none; en low freezes every register. Optional dead time after each step: SEVEN_SEG_MUX_BLANK_EN.
module seven_seg_mux #(
  parameter int DIGITS = 4,
  parameter int SEG_W  = 7,
  parameter int DIV    = 40000,
  parameter int CBITS  = 16,
  parameter int BLANK  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DIGITS*SEG_W-1:0]    seg_in,
  output logic [SEG_W-1:0]           segment,
  output logic [DIGITS-1:0]          digit_sel,
  output logic [$clog2(DIGITS)-1:0]  digit_idx,
  output logic                       tick,
  output logic                       frame
);

  localparam int IW = $clog2(DIGITS);

  // Reject illegal configurations at elaboration time.
  if (DIGITS < 2 || DIGITS > 16 || DIV < 1 || DIV > (2**CBITS - 1) ||
      BLANK < 0 || BLANK > DIV) begin : g_param_check
    $error("seven_seg_mux: illegal parameter combination");
  end

  logic [CBITS-1:0]        cnt;
  logic [DIGITS*SEG_W-1:0] shadow;
  logic [SEG_W-1:0]        seg_q;
  logic [DIGITS-1:0]       sel_q;

  logic                    step;
  logic                    wrap;
  logic [IW-1:0]           next_idx;

  // A step fires on the last enabled cycle of each divider period; wrap means the step lands on digit 0.
  always_comb begin
    step     = en && (cnt == CBITS'(DIV));
    wrap     = (digit_idx == IW'(DIGITS - 1));
    next_idx = wrap ? '0 : digit_idx + 1'b1;
  end

  // Refresh divider: counts 0..DIV while enabled, returning to 0 on the step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= step ? '0 : cnt + 1'b1;
    end
  end

  // Scan position and frame shadow; the shadow is refreshed only when the scan wraps to digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_idx <= IW'(DIGITS - 1);
      shadow    <= '0;
    end else if (step) begin
      digit_idx <= next_idx;
      if (wrap) begin
        shadow <= seg_in;
      end
    end
  end

  // Output registers; on a wrap the pattern comes straight from seg_in since the shadow is loading this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      sel_q <= '0;
      tick  <= 1'b0;
      frame <= 1'b0;
    end else begin
      tick  <= step;
      frame <= step && wrap;
      if (step) begin
        sel_q <= DIGITS'(1) << next_idx;
        seg_q <= wrap ? seg_in[0 +: SEG_W] : shadow[next_idx*SEG_W +: SEG_W];
      end
    end
  end

`ifdef SEVEN_SEG_MUX_BLANK_EN
  localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

  logic [BW-1:0] blank_cnt;

  // Dead-time counter: loaded at each step, counts down on enabled cycles; outputs stay dark while non-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_cnt <= '0;
    end else if (step) begin
      blank_cnt <= BW'(BLANK);
    end else if (en && (blank_cnt != '0)) begin
      blank_cnt <= blank_cnt - 1'b1;
    end
  end

  assign segment   = (blank_cnt != '0) ? '0 : seg_q;
  assign digit_sel = (blank_cnt != '0) ? '0 : sel_q;
`else
  assign segment   = seg_q;
  assign digit_sel = sel_q;
`endif

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: directed and randomized checks of seven_seg_mux against a frame-level reference model.
// The model tracks enabled cycles since reset and derives step, digit and frame from that count.
// Build with SEVEN_SEG_MUX_BLANK_EN defined to exercise the dead-time window.
module tb_seven_seg_mux;

  localparam int DIGITS = 4;
  localparam int SEG_W  = 7;
  localparam int DIV    = 3;
  localparam int CBITS  = 16;
  localparam int BLANK  = 2;
  localparam int PER    = DIV + 1;
`ifdef SEVEN_SEG_MUX_BLANK_EN
  localparam int BL = BLANK;
`else
  localparam int BL = 0;
`endif
  localparam int VW = SEG_W + DIGITS + 2 + 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en  = 1'b0;
  logic [DIGITS*SEG_W-1:0] seg_in = '0;
  logic [SEG_W-1:0]        segment;
  logic [DIGITS-1:0]       digit_sel;
  logic [1:0]              digit_idx;
  logic                    tick;
  logic                    frame;

  int checks = 0;
  int errors = 0;

  seven_seg_mux #(
    .DIGITS(DIGITS), .SEG_W(SEG_W), .DIV(DIV), .CBITS(CBITS), .BLANK(BLANK)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .seg_in(seg_in),
    .segment(segment), .digit_sel(digit_sel), .digit_idx(digit_idx),
    .tick(tick), .frame(frame)
  );

  always #5 clk = ~clk;

  wire [VW-1:0] obs = {segment, digit_sel, digit_idx, tick, frame};

  // Reference model state.
  int               n;
  logic [SEG_W-1:0] m_shadow [DIGITS];
  logic [SEG_W-1:0] m_seg;
  logic [DIGITS-1:0] m_sel;
  int               m_idx;
  bit               m_tick;
  bit               m_frame;
  int               m_blank;

  function automatic logic [VW-1:0] exp_vec();
    logic [SEG_W-1:0]  s;
    logic [DIGITS-1:0] d;
    logic [1:0]        i;
    s = (m_blank > 0) ? '0 : m_seg;
    d = (m_blank > 0) ? '0 : m_sel;
    i = 2'(m_idx);
    return {s, d, i, m_tick, m_frame};
  endfunction

  // Advance one clock edge, update the model from the inputs the DUT saw, then settle.
  task automatic step_clk();
    int s;
    @(posedge clk);
    if (rst) begin
      n = 0;
      for (int k = 0; k < DIGITS; k++) m_shadow[k] = '0;
      m_seg = '0; m_sel = '0; m_idx = DIGITS - 1;
      m_tick = 0; m_frame = 0; m_blank = 0;
    end else if (en) begin
      n++;
      m_tick  = (n % PER == 0);
      m_frame = 0;
      if (m_blank > 0) m_blank--;
      if (m_tick) begin
        s = n / PER;
        m_idx   = (s - 1) % DIGITS;
        m_frame = (m_idx == 0);
        if (m_frame)
          for (int k = 0; k < DIGITS; k++) m_shadow[k] = seg_in[k*SEG_W +: SEG_W];
        m_seg   = m_shadow[m_idx];
        m_sel   = DIGITS'(1) << m_idx;
        m_blank = BL;
      end
    end else begin
      m_tick = 0; m_frame = 0;
    end
    #1;
  endtask

  // Clock until tick is seen (bounded); returns the number of edges taken, or -1 on timeout.
  task automatic wait_tick(output int edges);
    edges = -1;
    for (int e = 1; e <= 4 * PER; e++) begin
      step_clk();
      if (tick === 1'b1) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    step_clk(); step_clk();
    checks++;
    if (obs !== {7'h00, 4'b0000, 2'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state got=%h want=%h", obs, {7'h00, 4'b0000, 2'd3, 1'b0, 1'b0});
    end
  endtask

  task automatic test_first_frame();
    logic [VW-1:0] want;
    seg_in = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    rst = 1'b0; en = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step_clk();
      checks++;
      if (digit_sel !== 4'b0000 || tick !== 1'b0) begin
        errors++; $display("FAIL first_dark edge=%0d sel=%b tick=%b want sel=0000 tick=0", e, digit_sel, tick);
      end
    end
    step_clk();
    want = {(BL > 0) ? 7'h00 : 7'h3F, (BL > 0) ? 4'b0000 : 4'b0001, 2'd0, 1'b1, 1'b1};
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL first_step got=%h want=%h", obs, want);
    end
  endtask

  task automatic test_scan();
    logic [SEG_W-1:0]  seg_tab [3] = '{7'h06, 7'h5B, 7'h4F};
    logic [DIGITS-1:0] sel_tab [3] = '{4'b0010, 4'b0100, 4'b1000};
    int edges;
    for (int j = 0; j < 3; j++) begin
      wait_tick(edges);
      checks++;
      if (edges != PER) begin
        errors++; $display("FAIL scan_period step=%0d edges=%0d want=%0d", j, edges, PER);
      end
      for (int b = 0; b < BL; b++) step_clk();
      checks++;
      if (segment !== seg_tab[j] || digit_sel !== sel_tab[j] || obs !== exp_vec()) begin
        errors++; $display("FAIL scan_digit step=%0d seg=%h sel=%b want seg=%h sel=%b", j, segment, digit_sel, seg_tab[j], sel_tab[j]);
      end
    end
    wait_tick(edges);
    checks++;
    if (edges != PER || frame !== 1'b1 || digit_idx !== 2'd0) begin
      errors++; $display("FAIL scan_wrap edges=%0d frame=%b idx=%0d want %0d 1 0", edges, frame, digit_idx, PER);
    end
  endtask

  task automatic test_frame_hold();
    int edges;
    seg_in[2*SEG_W +: SEG_W] = 7'h7F;
    wait_tick(edges); wait_tick(edges);
    for (int b = 0; b < BL; b++) step_clk();
    checks++;
    if (digit_idx !== 2'd2 || segment !== 7'h5B) begin
      errors++; $display("FAIL frame_hold_old idx=%0d seg=%h want 2 5b", digit_idx, segment);
    end
    for (int t = 0; t < 4; t++) wait_tick(edges);
    for (int b = 0; b < BL; b++) step_clk();
    checks++;
    if (digit_idx !== 2'd2 || segment !== 7'h7F || obs !== exp_vec()) begin
      errors++; $display("FAIL frame_hold_new idx=%0d seg=%h want 2 7f", digit_idx, segment);
    end
  endtask

  task automatic test_en_hold();
    logic [VW-1:0] held;
    int edges;
    wait_tick(edges);
    step_clk();
    held = obs;
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step_clk();
      checks++;
      if (obs !== held || tick !== 1'b0) begin
        errors++; $display("FAIL en_hold cycle=%0d got=%h want=%h", c, obs, held);
      end
    end
    en = 1'b1;
    wait_tick(edges);
    checks++;
    if (edges != PER - 1 || obs !== exp_vec()) begin
      errors++; $display("FAIL en_resume edges=%0d want=%0d got=%h model=%h", edges, PER - 1, obs, exp_vec());
    end
  endtask

  task automatic test_mid_reset();
    int edges;
    for (int t = 0; t < 8 && digit_idx !== 2'd2; t++) wait_tick(edges);
    checks++;
    if (digit_idx !== 2'd2) begin
      errors++; $display("FAIL mid_reset_reach idx=%0d want 2", digit_idx);
    end
    step_clk();
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    checks++;
    if (obs !== {7'h00, 4'b0000, 2'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset_state got=%h want=%h", obs, {7'h00, 4'b0000, 2'd3, 1'b0, 1'b0});
    end
    wait_tick(edges);
    checks++;
    if (edges != PER || frame !== 1'b1 || digit_idx !== 2'd0 || obs !== exp_vec()) begin
      errors++; $display("FAIL mid_reset_first edges=%0d frame=%b idx=%0d want %0d 1 0", edges, frame, digit_idx, PER);
    end
  endtask

  task automatic test_blank();
    int edges;
    wait_tick(edges);
    for (int k = 0; k <= BLANK; k++) begin
      checks++;
      if (digit_sel !== ((k < BL) ? 4'b0000 : m_sel) || segment !== ((k < BL) ? 7'h00 : m_seg)) begin
        errors++; $display("FAIL blank_window k=%0d sel=%b seg=%h want sel=%b seg=%h", k, digit_sel, segment,
                           (k < BL) ? 4'b0000 : m_sel, (k < BL) ? 7'h00 : m_seg);
      end
      step_clk();
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 3000; c++) begin
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) seg_in = DIGITS*SEG_W'($urandom);
      step_clk();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        if (bad < 10) $display("FAIL random cycle=%0d got=%h want=%h", c, obs, exp_vec());
        bad++;
      end
    end
    rst = 1'b0; en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_scan();
    test_frame_hold();
    test_en_hold();
    test_mid_reset();
    test_blank();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
